// File: rtl/mult_share_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package mult_share_pkg;

    localparam int W  = 8;
    localparam int PW = 2 * W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    // Ceiling log2 with a floor of 1 so a 1-bit index always exists.
    function automatic int clog2(input int n);
        int r;
        r = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_pick
    import mult_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    // Scan from the farthest candidate back to ptr so the nearest one wins.
    always_comb begin
        int idx;
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(ptr) + k) % NREQ;
            if (req[idx]) begin
                gnt_idx = IDW'(idx);
                any     = 1'b1;
            end
        end
        if (any) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one external signed 8x8 multiplier among
// NREQ requesters, returning a single ID-tagged response channel.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*W-1:0]      req_a,
    input  logic [NREQ*W-1:0]      req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic signed [PW-1:0]   rsp_p,
    output logic signed [W-1:0]    mul_x,
    output logic signed [W-1:0]    mul_y,
    input  logic signed [PW-1:0]   mul_p,
    output logic                   busy
);

    state_t                state;
    state_t                state_nx;
    logic [IDW-1:0]        rr_ptr;
    logic [IDW-1:0]        ptr_nx;
    logic [IDW-1:0]        owner;
    logic [NREQ-1:0]       gnt;
    logic [IDW-1:0]        gnt_idx;
    logic                  any;
    logic                  accept_win;
    logic                  hs;
    logic signed [W-1:0]   sel_a;
    logic signed [W-1:0]   sel_b;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    // New work may be taken when idle, or while the current response drains.
    // Reset is folded in so req_ready reads zero while rst_n is low.
    assign accept_win = rst_n &&
                        ((state == S_IDLE) || ((state == S_RSP) && rsp_ready));
    assign req_ready  = accept_win ? gnt : '0;
    assign hs         = accept_win && any;

    assign rsp_valid  = (state == S_RSP);
    assign busy       = (state == S_MUL) || (state == S_RSP);

    // Pointer moves one past the winner so the winner goes to the back.
    assign ptr_nx = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

    // Operand mux driven by the one-hot grant.
    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    // Next-state logic for the accept / multiply / respond sequence.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (hs) begin
                    state_nx = S_MUL;
                end
            end
            S_MUL: begin
                state_nx = S_RSP;
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_nx = hs ? S_MUL : S_IDLE;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Accept stage: latch the winner's operands, ownership and pointer.
    // Operands are held after use so the multiplier inputs stay quiet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_x  <= '0;
            mul_y  <= '0;
            owner  <= '0;
            rr_ptr <= '0;
        end else if (hs) begin
            mul_x  <= sel_a;
            mul_y  <= sel_b;
            owner  <= gnt_idx;
            rr_ptr <= ptr_nx;
        end
    end

    // Result stage: capture the product one cycle after the operands settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_p  <= '0;
            rsp_id <= '0;
        end else if (state == S_MUL) begin
            rsp_p  <= mul_p;
            rsp_id <= owner;
        end
    end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
Shares one combinational 8x8 signed (two's-complement) Wallace-tree multiplier (module wallace) among NREQ requesters. Each requester has a valid/ready request channel; the block returns one response channel tagged with the requester ID. It selects requesters by round-robin, registers the operands toward the multiplier, and captures its product into a result register. It sits between client engines and the single multiplier instance at the datapath top level.

Parameters:
NREQ, 4, number of requesters (2..8); ID width IDW = clog2(NREQ), minimum 1.
W, 8, operand width; fixed at 8 to match the multiplier; product width is 2*W.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; at most one bit high (one-hot)
req_a  in  NREQ*W  operand A, requester i at [i*W +: W], signed
req_b  in  NREQ*W  operand B, same packing, signed
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  IDW  requester index owning the response
rsp_p  out  2*W  signed product
mul_x  out  W  operand to multiplier x, driven directly from a register
mul_y  out  W  operand to multiplier y, driven directly from a register
mul_p  in  2*W  product from multiplier p, combinational from mul_x/mul_y
busy  out  1  high in S_MUL or S_RSP

Behaviour:
- Reset (async assert, sync deassert is handled by the top level):
  - state=S_IDLE; rr_ptr=0.
  - mul_x, mul_y, rsp_p, rsp_id = 0; rsp_valid=0; req_ready=0; busy=0.
- FSM states: S_IDLE, S_MUL, S_RSP.
- Accept window: the cycle is S_IDLE, or S_RSP with rsp_ready=1.
- Winner selection in the accept window:
  - Winner g is the first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[g]=1 combinationally; all other req_ready bits are 0.
  - req_ready=0 outside the accept window.
- On handshake (req_valid[g] & req_ready[g]):
  - mul_x<=req_a[g], mul_y<=req_b[g], owner<=g.
  - rr_ptr<=(g+1) mod NREQ.
  - state<=S_MUL.
- S_MUL, one cycle:
  - rsp_p<=mul_p, rsp_id<=owner, state<=S_RSP.
  - mul_x and mul_y stay stable for the whole cycle.
- S_RSP:
  - rsp_valid=1; rsp_p and rsp_id are held stable until rsp_ready.
  - On rsp_ready with a new handshake in the same cycle: state<=S_MUL (back-to-back).
  - On rsp_ready with no handshake: state<=S_IDLE.
  - With rsp_ready=0: stay in S_RSP, no accept.
- Latency: handshake at cycle T gives rsp_valid at T+2. Peak throughput is one product per 2 cycles.
- rr_ptr changes only on a handshake. With no requests it holds.
- A requester that deasserts req_valid before being granted loses nothing; no state is kept for it.
- Arithmetic: signed 8x8 -> 16-bit product, no truncation. The block passes mul_p through without modification; correctness of the product is the multiplier's.
- mul_x and mul_y keep their last operands while idle; they are not cleared after use.
- Reset mid-operation: any in-flight transaction is dropped with no response; the pointer returns to 0.
- A request that is only partly visible (valid without ready) must not change any register.

Decomposition:
- Package mult_share_pkg:
  - W=8, PW=16;
  - state encodings S_IDLE=2'd0, S_MUL=2'd1, S_RSP=2'd2;
  - function clog2.
- One natural sub-module, rr_pick:
  - combinational round-robin picker;
  - inputs: req vector, ptr;
  - outputs: one-hot grant, grant index, any.
- The multiplier is instantiated beside this block at the top level, not inside it.

Test Plan:
- Single request: req 1 with a=-3 (8'hFD), b=5, rsp_ready=1 -> req_ready[1] at T; rsp_valid at T+2 with rsp_id=1, rsp_p=16'hFFF1.
- Corner products:
  - (-128)*(-128) -> 16'h4000;
  - 127*(-128) -> 16'hC080;
  - 0*(-1) -> 16'h0000.
- Round-robin fairness: all 4 req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0; each response follows its grant by 2 cycles; the next grant coincides with each response.
- Backpressure: rsp_ready=0 for 5 cycles during S_RSP -> rsp_p and rsp_id held, req_ready all 0. rsp_ready=1 with req 2 valid -> same-cycle accept, next response 2 cycles later.
- Pointer hold: grant req 2, then idle for 10 cycles, then req 0 and req 3 both valid -> req 3 granted first (rr_ptr=3).
- Async reset: assert rst_n=0 in S_MUL -> all outputs 0 immediately and no rsp_valid. After release, req 1 is granted with ptr=0 priority ordering.
